// File: rtl/irq_scan_arbiter_pkg.sv
// Shared state encoding and wrap-increment helper for the scanning interrupt arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package irq_scan_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        GRANT = 2'd2
    } state_t;

    // Explicit wrap so non-power-of-2 widths never produce an out-of-range index.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned width);
        return (idx == width - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/irq_scan_arbiter_if.sv
// Request/grant bundle between the request sources, the scanning arbiter and its consumer.
// Latency: n/a (wiring only); optional stats outputs appear when IRQ_SCAN_STATS_EN is defined.
// Backpressure: grant_valid/grant_id held by the arbiter until grant_ack.
interface irq_scan_arbiter_if #(
    parameter int WIDTH = 32
);
    localparam int POW = $clog2(WIDTH);

    logic             enable;
    logic [WIDTH-1:0] req;
    logic [WIDTH-1:0] mask;
    logic             grant_valid;
    logic [POW-1:0]   grant_id;
    logic             grant_ack;
    logic             busy;
    logic [POW-1:0]   scan_idx;
`ifdef IRQ_SCAN_STATS_EN
    logic [31:0]      grant_cnt;
    logic [15:0]      miss_cnt;
`endif

    modport master (
        input  enable, req, mask, grant_ack,
`ifdef IRQ_SCAN_STATS_EN
        output grant_cnt, miss_cnt,
`endif
        output grant_valid, grant_id, busy, scan_idx
    );

    modport slave (
        output enable, req, mask, grant_ack,
`ifdef IRQ_SCAN_STATS_EN
        input  grant_cnt, miss_cnt,
`endif
        input  grant_valid, grant_id, busy, scan_idx
    );

endinterface

// File: rtl/irq_scan_arbiter_bitsel.sv
// Generic single-bit selector: hit = din[sel], zero for any index beyond WIDTH-1.
// Latency: combinational.
// Backpressure: none.
module irq_scan_arbiter_bitsel #(
    parameter  int WIDTH = 32,
    localparam int POW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] din,
    input  logic [POW-1:0]   sel,
    output logic             hit
);

    assign hit = (sel <= POW'(WIDTH - 1)) ? din[sel] : 1'b0;

endmodule

// File: rtl/irq_scan_arbiter.sv
// Round-robin scanning arbiter: walks one mux index per cycle over req&mask and grants the first hit.
// Latency: grant_valid rises k+2 cycles after a request is seen idle (k = offset from ptr), at most WIDTH+1.
// Backpressure: grant held stable until grant_ack; stats counters exist only with IRQ_SCAN_STATS_EN.
module irq_scan_arbiter
    import irq_scan_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    irq_scan_arbiter_if.master bus
);

    localparam int             POW  = $clog2(WIDTH);
    localparam logic [POW-1:0] LAST = POW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [POW-1:0]   ptr_q, ptr_d;
    logic [POW-1:0]   idx_q, idx_d;
    logic [POW-1:0]   cnt_q, cnt_d;
    logic [POW-1:0]   gid_q, gid_d;
    logic             gvld_q, gvld_d;
    logic [WIDTH-1:0] eff_req;
    logic             any_req;
    logic             hit;
    logic             accept;
    logic             lap_miss;

    function automatic logic [POW-1:0] nxt(input logic [POW-1:0] i);
        return POW'(wrap_inc(32'(i), WIDTH));
    endfunction

    assign eff_req = bus.req & bus.mask;
    assign any_req = |eff_req;

    irq_scan_arbiter_bitsel #(.WIDTH(WIDTH)) u_bitsel (
        .din (eff_req),
        .sel (idx_q),
        .hit (hit)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        gid_d    = gid_q;
        gvld_d   = gvld_q;
        accept   = 1'b0;
        lap_miss = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enable && any_req) begin
                    state_d = SCAN;
                    idx_d   = ptr_q;
                    cnt_d   = '0;
                end
            end
            SCAN: begin
                // Disable wins over a same-cycle hit: an aborted scan never grants.
                if (!bus.enable) begin
                    state_d = IDLE;
                end else if (hit) begin
                    gid_d   = idx_q;
                    gvld_d  = 1'b1;
                    state_d = GRANT;
                end else if (cnt_q == LAST) begin
                    state_d  = IDLE;
                    lap_miss = 1'b1;
                end else begin
                    idx_d = nxt(idx_q);
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GRANT: begin
                if (gvld_q && bus.grant_ack) begin
                    accept = 1'b1;
                    gvld_d = 1'b0;
                    ptr_d  = nxt(gid_q);
                    if (bus.enable && any_req) begin
                        state_d = SCAN;
                        idx_d   = nxt(gid_q);
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            gid_q   <= '0;
            gvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            gid_q   <= gid_d;
            gvld_q  <= gvld_d;
        end
    end

    assign bus.grant_valid = gvld_q;
    assign bus.grant_id    = gid_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.scan_idx    = idx_q;

`ifdef IRQ_SCAN_STATS_EN
    logic [31:0] grant_cnt_q;
    logic [15:0] miss_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_q <= '0;
            miss_cnt_q  <= '0;
        end else begin
            if (accept && (grant_cnt_q != '1)) grant_cnt_q <= grant_cnt_q + 1'b1;
            if (lap_miss && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 1'b1;
        end
    end

    assign bus.grant_cnt = grant_cnt_q;
    assign bus.miss_cnt  = miss_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = accept ^ lap_miss;
`endif

endmodule

// File: tb/tb_irq_scan_arbiter.sv
// Bench for the scanning arbiter: randomized requests against a cyclic-priority reference model,
// plus directed reset, hold, abort and non-power-of-2 wrap scenarios.
module tb_irq_scan_arbiter;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   ptr32;
    int   ptr5;

    irq_scan_arbiter_if #(.WIDTH(32)) b32 ();
    irq_scan_arbiter_if #(.WIDTH(5))  b5 ();

    irq_scan_arbiter #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    irq_scan_arbiter #(.WIDTH(5))  u5  (.clk(clk), .rst_n(rst_n), .bus(b5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: first effective line at or after p, walking cyclically; -1 if none.
    function automatic int exp_winner(input int p, input logic [31:0] eff, input int w);
        for (int k = 0; k < w; k++) begin
            if (eff[(p + k) % w]) return (p + k) % w;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        b32.enable = 1'b0; b32.req = '0; b32.mask = '1; b32.grant_ack = 1'b0;
        b5.enable  = 1'b0; b5.req  = '0; b5.mask  = '1; b5.grant_ack  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        ptr32 = 0;
        ptr5  = 0;
    endtask

    task automatic wait_gv32(input int start, output int lat);
        lat = start;
        while (b32.grant_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        if (b32.grant_valid !== 1'b1) lat = -1;
    endtask

    task automatic wait_gv5(input int start, output int lat, output int maxidx);
        lat    = start;
        maxidx = int'(b5.scan_idx);
        while (b5.grant_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
            if (int'(b5.scan_idx) > maxidx) maxidx = int'(b5.scan_idx);
        end
        if (b5.grant_valid !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        int lat;
        bit busy_ok;
        b32.req = 32'h0000_0100; b32.mask = '1; b32.enable = 1'b1; b32.grant_ack = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({b32.grant_valid, b32.grant_id, b32.busy, b32.scan_idx} !== '0) begin
            n_fail++;
            $display("FAIL reset_vals: got gv=%b id=%0d busy=%b idx=%0d, want all 0",
                     b32.grant_valid, b32.grant_id, b32.busy, b32.scan_idx);
        end
        rst_n = 1'b1;
        ptr32 = 0; ptr5 = 0;
        wait_gv32(0, lat);
        n_tests++;
        if (lat != 10 || int'(b32.grant_id) != 8) begin
            n_fail++;
            $display("FAIL reset_first_grant: got lat=%0d id=%0d, want lat=10 id=8", lat, b32.grant_id);
        end
        busy_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (b32.busy !== 1'b1 || b32.grant_valid !== 1'b1) busy_ok = 1'b0;
        end
        n_tests++;
        if (!busy_ok) begin
            n_fail++;
            $display("FAIL reset_busy_hold: got busy=%b gv=%b, want 1 1", b32.busy, b32.grant_valid);
        end
        b32.grant_ack = 1'b1; b32.req = '0;
        tick();
        b32.grant_ack = 1'b0;
        ptr32 = 9;
        n_tests++;
        if (b32.busy !== 1'b0 || b32.grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ack_idle: got busy=%b gv=%b, want 0 0", b32.busy, b32.grant_valid);
        end
    endtask

    task automatic test_round_robin();
        int lat;
        int exp_id;
        int k;
        do_reset();
        b32.req = 32'h8000_0001; b32.mask = '1; b32.enable = 1'b1;
        lat = 0;
        for (int g = 0; g < 4; g++) begin
            exp_id = exp_winner(ptr32, b32.req & b32.mask, 32);
            k = (exp_id - ptr32 + 32) % 32;
            wait_gv32(lat, lat);
            n_tests++;
            if (lat != k + 2 || int'(b32.grant_id) != exp_id) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got lat=%0d id=%0d, want lat=%0d id=%0d",
                         g, lat, b32.grant_id, k + 2, exp_id);
            end
            ptr32 = (exp_id + 1) % 32;
            b32.grant_ack = 1'b1;
            if (g == 3) b32.req = '0;
            tick();
            b32.grant_ack = 1'b0;
            lat = 1;
        end
        n_tests++;
        if (b32.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_end_idle: got busy=%b, want 0", b32.busy);
        end
    endtask

    task automatic test_random();
        int lat;
        int exp_id;
        int k;
        bit quiet;
        logic [31:0] r;
        for (int it = 0; it < 30; it++) begin
            r = $urandom() & $urandom();
            if ($urandom_range(0, 3) == 0) r = 32'd1 << $urandom_range(0, 31);
            b32.req  = r;
            b32.mask = $urandom() | $urandom();
            if ($urandom_range(0, 5) == 0) b32.mask = '0;
            b32.enable = 1'b1;
            exp_id = exp_winner(ptr32, b32.req & b32.mask, 32);
            if (exp_id < 0) begin
                quiet = 1'b1;
                for (int i = 0; i < 36; i++) begin
                    tick();
                    if (b32.busy !== 1'b0 || b32.grant_valid !== 1'b0) quiet = 1'b0;
                end
                n_tests++;
                if (!quiet) begin
                    n_fail++;
                    $display("FAIL rand%0d_noreq: got busy=%b gv=%b, want 0 0", it, b32.busy, b32.grant_valid);
                end
            end else begin
                k = (exp_id - ptr32 + 32) % 32;
                wait_gv32(0, lat);
                n_tests++;
                if (lat != k + 2 || int'(b32.grant_id) != exp_id) begin
                    n_fail++;
                    $display("FAIL rand%0d_grant: got lat=%0d id=%0d, want lat=%0d id=%0d",
                             it, lat, b32.grant_id, k + 2, exp_id);
                end
                ptr32 = (exp_id + 1) % 32;
                b32.grant_ack = 1'b1; b32.req = '0;
                tick();
                b32.grant_ack = 1'b0;
            end
        end
        b32.req = '0;
    endtask

    task automatic test_mask();
        int lat;
        int k;
        bit quiet;
        b32.req = 32'h0000_0010; b32.mask = '0; b32.enable = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (b32.busy !== 1'b0 || b32.grant_valid !== 1'b0) quiet = 1'b0;
        end
        n_tests++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL mask_zero_idle: got busy=%b gv=%b, want 0 0", b32.busy, b32.grant_valid);
        end
        b32.mask = 32'h0000_0010;
        k = (4 - ptr32 + 32) % 32;
        wait_gv32(0, lat);
        n_tests++;
        if (lat != k + 2 || int'(b32.grant_id) != 4) begin
            n_fail++;
            $display("FAIL mask_bit4_grant: got lat=%0d id=%0d, want lat=%0d id=4", lat, b32.grant_id, k + 2);
        end
        ptr32 = 5;
        b32.grant_ack = 1'b1; b32.req = '0; b32.mask = '1;
        tick();
        b32.grant_ack = 1'b0;
    endtask

    task automatic test_hold();
        int lat;
        bit stable;
        b32.req = 32'h0000_0020; b32.enable = 1'b1;
        wait_gv32(0, lat);
        n_tests++;
        if (int'(b32.grant_id) != 5 || lat != ((5 - ptr32 + 32) % 32) + 2) begin
            n_fail++;
            $display("FAIL hold_grant: got lat=%0d id=%0d, want id=5", lat, b32.grant_id);
        end
        b32.req = '0;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) b32.enable = 1'b0;
            if (i == 15) b32.mask = '0;
            tick();
            if (b32.grant_valid !== 1'b1 || int'(b32.grant_id) != 5 || b32.busy !== 1'b1) stable = 1'b0;
        end
        n_tests++;
        if (!stable) begin
            n_fail++;
            $display("FAIL hold_stable: got gv=%b id=%0d, want 1 5", b32.grant_valid, b32.grant_id);
        end
        b32.enable = 1'b1; b32.mask = '1; b32.grant_ack = 1'b1;
        tick();
        b32.grant_ack = 1'b0;
        ptr32 = 6;
        n_tests++;
        if (b32.grant_valid !== 1'b0 || b32.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_ack_idle: got gv=%b busy=%b, want 0 0", b32.grant_valid, b32.busy);
        end
    endtask

    task automatic test_abort();
        int lat;
        int k;
        bit quiet;
        b32.req = 32'h0010_0000; b32.enable = 1'b1;
        k = (20 - ptr32 + 32) % 32;
        for (int i = 0; i < 5; i++) tick();
        b32.enable = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (b32.busy !== 1'b0 || b32.grant_valid !== 1'b0) quiet = 1'b0;
        end
        n_tests++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL abort_idle: got busy=%b gv=%b, want 0 0", b32.busy, b32.grant_valid);
        end
        b32.enable = 1'b1;
        wait_gv32(0, lat);
        n_tests++;
        if (lat != k + 2 || int'(b32.grant_id) != 20) begin
            n_fail++;
            $display("FAIL abort_ptr_kept: got lat=%0d id=%0d, want lat=%0d id=20", lat, b32.grant_id, k + 2);
        end
        b32.grant_ack = 1'b1; b32.req = '0;
        tick();
        b32.grant_ack = 1'b0;
        ptr32 = 21;
    endtask

    task automatic test_reset_midscan();
        int lat;
        int guard;
        do_reset();
        b32.req = 32'h0010_0000; b32.enable = 1'b1;
        guard = 0;
        while (int'(b32.scan_idx) != 12 && guard < 40) begin
            tick();
            guard++;
        end
        n_tests++;
        if (int'(b32.scan_idx) != 12 || b32.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midscan_reach12: got idx=%0d busy=%b, want 12 1", b32.scan_idx, b32.busy);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({b32.grant_valid, b32.grant_id, b32.busy, b32.scan_idx} !== '0) begin
            n_fail++;
            $display("FAIL midscan_async_reset: got gv=%b id=%0d busy=%b idx=%0d, want all 0",
                     b32.grant_valid, b32.grant_id, b32.busy, b32.scan_idx);
        end
        b32.req = 32'h0000_0008;
        @(negedge clk);
        rst_n = 1'b1;
        ptr32 = 0;
        wait_gv32(0, lat);
        n_tests++;
        if (lat != 5 || int'(b32.grant_id) != 3) begin
            n_fail++;
            $display("FAIL midscan_ptr_zero: got lat=%0d id=%0d, want lat=5 id=3", lat, b32.grant_id);
        end
        b32.grant_ack = 1'b1; b32.req = '0;
        tick();
        b32.grant_ack = 1'b0;
        ptr32 = 4;
    endtask

    task automatic test_width5();
        int lat;
        int maxidx;
        bit inrange;
        do_reset();
        b5.req = 5'b10000; b5.mask = '1; b5.enable = 1'b1;
        wait_gv5(0, lat, maxidx);
        n_tests++;
        if (lat != 6 || int'(b5.grant_id) != 4 || maxidx > 4) begin
            n_fail++;
            $display("FAIL w5_grant4: got lat=%0d id=%0d maxidx=%0d, want lat=6 id=4 maxidx<=4",
                     lat, b5.grant_id, maxidx);
        end
        b5.grant_ack = 1'b1; b5.req = 5'b00001;
        tick();
        b5.grant_ack = 1'b0;
        n_tests++;
        if (int'(b5.scan_idx) != 0 || b5.busy !== 1'b1 || b5.grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL w5_wrap_idx: got idx=%0d busy=%b gv=%b, want 0 1 0", b5.scan_idx, b5.busy, b5.grant_valid);
        end
        wait_gv5(1, lat, maxidx);
        n_tests++;
        if (lat != 2 || int'(b5.grant_id) != 0) begin
            n_fail++;
            $display("FAIL w5_grant0: got lat=%0d id=%0d, want lat=2 id=0", lat, b5.grant_id);
        end
        b5.grant_ack = 1'b1; b5.req = '0;
        tick();
        b5.grant_ack = 1'b0;
        ptr5 = 1;
        // Request vanishes once the scan starts: a full empty lap from ptr=1 must wrap 4 -> 0.
        b5.req = 5'b00100;
        tick();
        b5.req = '0;
        inrange = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (int'(b5.scan_idx) > 4 || b5.busy !== 1'b1) inrange = 1'b0;
        end
        n_tests++;
        if (!inrange || int'(b5.scan_idx) != 0) begin
            n_fail++;
            $display("FAIL w5_lap_wrap: got idx=%0d busy=%b, want idx=0 busy=1 in range", b5.scan_idx, b5.busy);
        end
        tick();
        n_tests++;
        if (b5.busy !== 1'b0 || b5.grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL w5_lap_idle: got busy=%b gv=%b, want 0 0", b5.busy, b5.grant_valid);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        ptr32   = 0;
        ptr5    = 0;
        rst_n   = 1'b0;
        b32.enable = 1'b0; b32.req = '0; b32.mask = '1; b32.grant_ack = 1'b0;
        b5.enable  = 1'b0; b5.req  = '0; b5.mask  = '1; b5.grant_ack  = 1'b0;
        test_reset();
        test_round_robin();
        test_random();
        test_mask();
        test_hold();
        test_abort();
        test_reset_midscan();
        test_width5();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
